// File: rtl/sub_pilot_mapper_if.sv
// Stream interface of the Tx subcarrier mapper: QAM data in, tagged subcarriers out.
// Both sides use valid/ready: a beat transfers on the rising clk edge where valid and ready are both high,
// and the source holds valid and its payload stable until then. Ready may depend on the sink's state.
interface sub_pilot_mapper_if #(
  parameter int FFT_DEPTH = 12
);
  logic                        en;
  logic                        ival;
  logic                        iready;
  logic signed [FFT_DEPTH-1:0] idata_i;
  logic signed [FFT_DEPTH-1:0] idata_q;
  logic                        ordy;
  logic                        oval;
  logic                        osop;
  logic                        oeop;
  logic [1:0]                  oindex;
  logic signed [FFT_DEPTH-1:0] osub_i;
  logic signed [FFT_DEPTH-1:0] osub_q;
  logic [15:0]                 osym_cnt;

  modport master (
    output en, ival, idata_i, idata_q, ordy,
    input  iready, oval, osop, oeop, oindex, osub_i, osub_q, osym_cnt
  );

  modport slave (
    input  en, ival, idata_i, idata_q, ordy,
    output iready, oval, osop, oeop, oindex, osub_i, osub_q, osym_cnt
  );
endinterface

// File: rtl/sub_pilot_mapper.sv
// Tx subcarrier mapper: left guard, N_PILOT x (pilot + STEP_PILOT data), right guard per OFDM symbol.
// Every subcarrier is tagged 0 null / 1 data / 2 pilot; pilot polarity follows PILOT_SEQ, LSB first.
module sub_pilot_mapper #(
  parameter int                 FFT_DEPTH   = 12,
  parameter int                 N_SUB       = 64,
  parameter int                 N_GUARD_L   = 6,
  parameter int                 N_PILOT     = 4,
  parameter int                 STEP_PILOT  = 12,
  parameter int                 LEVEL_PILOT = 2000,
  parameter logic [N_PILOT-1:0] PILOT_SEQ   = 4'b1011
) (
  input  logic                clk,
  input  logic                rst,
  sub_pilot_mapper_if.slave   bus,
  output logic [2:0]          o_dbg_state
);

  localparam int N_GUARD_R = N_SUB - N_GUARD_L - N_PILOT * (STEP_PILOT + 1);
  localparam int SUB_W     = $clog2(N_SUB);
  localparam int DATA_W    = $clog2(STEP_PILOT + 1);
  localparam int PIL_W     = $clog2(N_PILOT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GUARD_L = 3'd1;
  localparam logic [2:0] S_PILOT   = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_GUARD_R = 3'd4;
  localparam logic [2:0] S_FIRST   = (N_GUARD_L == 0) ? S_PILOT : S_GUARD_L;

  localparam logic signed [FFT_DEPTH-1:0] P_POS = FFT_DEPTH'(LEVEL_PILOT);
  localparam logic signed [FFT_DEPTH-1:0] P_NEG = -P_POS;

  generate
    if (N_GUARD_L + N_PILOT * (STEP_PILOT + 1) > N_SUB) begin : g_bad_layout
      $error("sub_pilot_mapper: guard + pilot groups exceed N_SUB");
    end
    if (LEVEL_PILOT >= (1 << (FFT_DEPTH - 1))) begin : g_bad_level
      $error("sub_pilot_mapper: LEVEL_PILOT does not fit FFT_DEPTH signed");
    end
  endgenerate

  logic [2:0]                  r_state;
  logic [SUB_W-1:0]            r_sub_cnt;
  logic [DATA_W-1:0]           r_data_cnt;
  logic [PIL_W-1:0]            r_pilot_cnt;
  logic [N_PILOT-1:0]          r_pilot_sr;
  logic                        r_oval;
  logic                        r_osop;
  logic                        r_oeop;
  logic [1:0]                  r_oindex;
  logic signed [FFT_DEPTH-1:0] r_osub_i;
  logic signed [FFT_DEPTH-1:0] r_osub_q;
  logic [15:0]                 r_osym_cnt;

  logic                        w_adv;
  logic                        w_in_data;
  logic                        w_emit;
  logic                        w_data_last;
  logic                        w_groups_done;
  logic                        w_sym_end;
  logic [1:0]                  w_idx;
  logic signed [FFT_DEPTH-1:0] w_i;
  logic signed [FFT_DEPTH-1:0] w_q;

  assign w_adv         = ~r_oval | bus.ordy;
  assign w_in_data     = (r_state == S_DATA);
  assign w_emit        = w_adv & ((r_state == S_GUARD_L) | (r_state == S_PILOT) |
                                  (r_state == S_GUARD_R) | (w_in_data & bus.ival));
  assign w_data_last   = (r_data_cnt == DATA_W'(STEP_PILOT - 1));
  assign w_groups_done = (r_pilot_cnt == PIL_W'(N_PILOT));
  // With no right guard the symbol ends on the last data subcarrier of the last group.
  assign w_sym_end     = w_emit & (((r_state == S_GUARD_R) & (r_sub_cnt == SUB_W'(N_SUB - 1))) |
                                   (w_in_data & w_data_last & w_groups_done & (N_GUARD_R == 0)));

  always_comb begin
    w_idx = 2'd0;
    w_i   = '0;
    w_q   = '0;
    case (r_state)
      S_PILOT: begin
        w_idx = 2'd2;
        w_i   = r_pilot_sr[0] ? P_POS : P_NEG;
        w_q   = r_pilot_sr[0] ? P_POS : P_NEG;
      end
      S_DATA: begin
        w_idx = 2'd1;
        w_i   = bus.idata_i;
        w_q   = bus.idata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sub_cnt   <= '0;
      r_data_cnt  <= '0;
      r_pilot_cnt <= '0;
      r_pilot_sr  <= PILOT_SEQ;
      r_oval      <= 1'b0;
      r_osop      <= 1'b0;
      r_oeop      <= 1'b0;
      r_oindex    <= 2'd0;
      r_osub_i    <= '0;
      r_osub_q    <= '0;
      r_osym_cnt  <= '0;
    end else begin
      if (w_adv) begin
        r_oval <= w_emit;
        r_osop <= w_emit & (r_sub_cnt == '0);
        r_oeop <= w_emit & (r_sub_cnt == SUB_W'(N_SUB - 1));
        if (w_emit) begin
          r_oindex <= w_idx;
          r_osub_i <= w_i;
          r_osub_q <= w_q;
        end
      end
      if (r_oval & r_oeop & bus.ordy) begin
        r_osym_cnt <= r_osym_cnt + 16'd1;
      end

      if (r_state == S_IDLE) begin
        if (bus.en) begin
          r_state     <= S_FIRST;
          r_sub_cnt   <= '0;
          r_data_cnt  <= '0;
          r_pilot_cnt <= '0;
          r_pilot_sr  <= PILOT_SEQ;
        end
      end else if (w_sym_end) begin
        r_state     <= bus.en ? S_FIRST : S_IDLE;
        r_sub_cnt   <= '0;
        r_data_cnt  <= '0;
        r_pilot_cnt <= '0;
        r_pilot_sr  <= PILOT_SEQ;
      end else if (w_emit) begin
        r_sub_cnt <= r_sub_cnt + SUB_W'(1);
        case (r_state)
          S_GUARD_L: begin
            if (r_sub_cnt == SUB_W'(N_GUARD_L - 1)) r_state <= S_PILOT;
          end
          S_PILOT: begin
            r_state     <= S_DATA;
            r_data_cnt  <= '0;
            r_pilot_cnt <= r_pilot_cnt + PIL_W'(1);
            r_pilot_sr  <= r_pilot_sr >> 1;
          end
          S_DATA: begin
            if (w_data_last) begin
              r_data_cnt <= '0;
              r_state    <= w_groups_done ? S_GUARD_R : S_PILOT;
            end else begin
              r_data_cnt <= r_data_cnt + DATA_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.iready   = w_adv & w_in_data;
  assign bus.oval     = r_oval;
  assign bus.osop     = r_osop;
  assign bus.oeop     = r_oeop;
  assign bus.oindex   = r_oindex;
  assign bus.osub_i   = r_osub_i;
  assign bus.osub_q   = r_osub_q;
  assign bus.osym_cnt = r_osym_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sub_pilot_mapper.sv
// Bench for sub_pilot_mapper: directed symbol runs checked beat by beat against a layout model and a data queue.
module tb_sub_pilot_mapper;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  sub_pilot_mapper_if #(.FFT_DEPTH(12)) bus ();

  sub_pilot_mapper #(
    .FFT_DEPTH(12), .N_SUB(64), .N_GUARD_L(6), .N_PILOT(4),
    .STEP_PILOT(12), .LEVEL_PILOT(2000), .PILOT_SEQ(4'b1011)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard state
  logic [23:0] exp_q[$];
  int beat, tot_beat, sym_done, in_cnt;
  int gap_left, gap_used;
  int cfg_bp, cfg_gap_at, cfg_en_off;
  int pilot_lv[4] = '{2000, 2000, -2000, 2000};

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (beat %0d, t=%0t)", tag, got, exp, tot_beat, $time);
    end
  endtask

  task automatic check_beat();
    int e_idx;
    int e_val;
    logic [23:0] d;
    if (beat < 6 || beat >= 58) e_idx = 0;
    else if ((beat - 6) % 13 == 0) e_idx = 2;
    else e_idx = 1;
    check("osop", 32'(bus.osop), 32'(beat == 0));
    check("oeop", 32'(bus.oeop), 32'(beat == 63));
    check("oindex", 32'(bus.oindex), e_idx);
    if (e_idx == 1) begin
      check("data_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        check("data_i", 32'(bus.osub_i), 32'($signed(d[23:12])));
        check("data_q", 32'(bus.osub_q), 32'($signed(d[11:0])));
      end
    end else begin
      e_val = (e_idx == 2) ? pilot_lv[(beat - 6) / 13] : 0;
      check("sub_i", 32'(bus.osub_i), e_val);
      check("sub_q", 32'(bus.osub_q), e_val);
    end
    beat++;
    tot_beat++;
    if (beat == 64) begin
      beat = 0;
      sym_done++;
      check("in_count", in_cnt, 48 * sym_done);
    end
  endtask

  // driver: one clock of stimulus, sampled and driven around the falling edge
  task automatic step();
    logic        held;
    logic [28:0] snap;
    int          gap_cyc;
    if (cfg_gap_at >= 0 && gap_used == 0 && in_cnt == cfg_gap_at) begin
      gap_left = 3;
      gap_used = 1;
    end
    gap_cyc = (gap_left > 0) ? 1 : 0;
    if (gap_left > 0) gap_left--;
    bus.en      = (tot_beat < cfg_en_off);
    bus.ival    = (gap_cyc == 0);
    bus.idata_i = 12'(100 + in_cnt);
    bus.idata_q = 12'(-7 * in_cnt - 1);
    bus.ordy    = (cfg_bp != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    if (bus.oval && !bus.ordy) check("iready_bp", 32'(bus.iready), 0);
    held = bus.oval & ~bus.ordy;
    snap = {bus.oval, bus.osop, bus.oeop, bus.oindex, bus.osub_i, bus.osub_q};
    if (bus.ival && bus.iready) begin
      exp_q.push_back({bus.idata_i, bus.idata_q});
      in_cnt++;
    end
    if (bus.oval && bus.ordy) check_beat();
    @(posedge clk);
    @(negedge clk);
    if (held) check("hold", 32'({bus.oval, bus.osop, bus.oeop, bus.oindex, bus.osub_i, bus.osub_q}), 32'(snap));
    if (gap_cyc != 0 && cfg_bp == 0) check("bubble", 32'(bus.oval), 0);
  endtask

  task automatic clear_model(input int bp, input int gap_at, input int en_off);
    cfg_bp = bp; cfg_gap_at = gap_at; cfg_en_off = en_off;
    beat = 0; tot_beat = 0; sym_done = 0; in_cnt = 0;
    gap_left = 0; gap_used = 0;
    exp_q.delete();
  endtask

  task automatic run(input int nsym, input int bp, input int gap_at, input int en_off);
    clear_model(bp, gap_at, en_off);
    for (int c = 0; c < 3000 && sym_done < nsym; c++) step();
    check("sym_done", sym_done, nsym);
    bus.en   = 1'b0;
    bus.ival = 1'b0;
    bus.ordy = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_oval", 32'(bus.oval), 0);
    end
    check("idle_state", 32'(dbg_state), 0);
    check("q_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.ival = 1'b0; bus.ordy = 1'b1;
    bus.idata_i = '0; bus.idata_q = '0;
    clear_model(0, -1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oval", 32'(bus.oval), 0);
    check("rst_osop", 32'(bus.osop), 0);
    check("rst_oeop", 32'(bus.oeop), 0);
    check("rst_iready", 32'(bus.iready), 0);
    check("rst_oindex", 32'(bus.oindex), 0);
    check("rst_osub_i", 32'(bus.osub_i), 0);
    check("rst_osub_q", 32'(bus.osub_q), 0);
    check("rst_osym_cnt", 32'(bus.osym_cnt), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // single and back-to-back symbols, en dropped inside the second
    run(2, 0, -1, 100);
    check("sym_cnt_2", 32'(bus.osym_cnt), 2);

    // input underrun of 3 cycles mid-DATA
    run(1, 0, 20, 30);

    // random downstream backpressure
    run(1, 1, -1, 30);

    // en deasserted at beat 20
    run(1, 0, -1, 20);
    check("sym_cnt_5", 32'(bus.osym_cnt), 5);

    // reset in the middle of a symbol
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst2_osym_cnt", 32'(bus.osym_cnt), 0);
    clear_model(0, -1, 1000);
    for (int c = 0; c < 500 && tot_beat < 30; c++) step();
    check("pre_rst_beats", tot_beat, 30);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_oval", 32'(bus.oval), 0);
    check("midrst_osym_cnt", 32'(bus.osym_cnt), 0);
    check("midrst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    run(1, 0, -1, 30);
    check("sym_cnt_after_rst", 32'(bus.osym_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
